// File: rtl/pipe_stage_skid_reg_pkg.sv
// Shared constants, stage indices and the per-cycle action decode for
// pipeline boundary registers.
package pipe_stage_skid_reg_pkg;

    localparam logic        RST_ENABLE = 1'b0;
    localparam logic        STOP       = 1'b1;
    localparam logic        NOT_STOP   = 1'b0;
    localparam logic [31:0] ZEROWORD   = 32'h0000_0000;

    // Values for the STAGE parameter: the upstream side's bit in the stall vector.
    localparam int PIPE_STAGE_IF  = 1;
    localparam int PIPE_STAGE_ID  = 2;
    localparam int PIPE_STAGE_EX  = 3;
    localparam int PIPE_STAGE_MEM = 4;

    typedef enum logic [2:0] {
        ACT_RESET,
        ACT_FLUSH,
        ACT_BUBBLE,
        ACT_HOLD,
        ACT_ADVANCE
    } pipe_action_e;

    // Reset beats flush, flush beats any stall, and stall beats advance.
    function automatic pipe_action_e decode_action(input logic rst_n, input logic flush,
                                                   input logic up, input logic dn);
        pipe_action_e act;
        if (rst_n == RST_ENABLE)              act = ACT_RESET;
        else if (flush)                       act = ACT_FLUSH;
        else if (up == STOP && dn == NOT_STOP) act = ACT_BUBBLE;
        else if (up == STOP)                  act = ACT_HOLD;
        else                                  act = ACT_ADVANCE;
        return act;
    endfunction

endpackage

// File: rtl/pipe_stage_skid_reg_if.sv
// Handshake bundle between the upstream stage, the boundary register and the
// downstream stage.
interface pipe_stage_skid_reg_if #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
);
    logic [5:0]        stall;
    logic              flush;
    logic              if_valid;
    logic [ADDR_W-1:0] if_pc;
    logic [DATA_W-1:0] if_inst;
    logic              id_valid;
    logic [ADDR_W-1:0] id_pc;
    logic [DATA_W-1:0] id_inst;
    logic              skid_full;

    modport master (
        output stall, flush, if_valid, if_pc, if_inst,
        input  id_valid, id_pc, id_inst, skid_full
    );

    modport slave (
        input  stall, flush, if_valid, if_pc, if_inst,
        output id_valid, id_pc, id_inst, skid_full
    );
endinterface

// File: rtl/pipe_stage_skid_reg_skid_entry.sv
// One-entry {pc,inst} holding buffer; load wins over drain so a simultaneous
// drain+load leaves it full with the newer entry.
module skid_entry
    import pipe_stage_skid_reg_pkg::*;
#(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              load,
    input  logic              drain,
    input  logic              clear,
    input  logic [ADDR_W-1:0] in_pc,
    input  logic [DATA_W-1:0] in_inst,
    output logic              valid,
    output logic [ADDR_W-1:0] out_pc,
    output logic [DATA_W-1:0] out_inst
);

    always_ff @(posedge clk) begin
        if (rst == RST_ENABLE || clear) begin
            valid    <= 1'b0;
            out_pc   <= '0;
            out_inst <= '0;
        end else if (load) begin
            valid    <= 1'b1;
            out_pc   <= in_pc;
            out_inst <= in_inst;
        end else if (drain) begin
            valid    <= 1'b0;
        end
    end

endmodule

// File: rtl/pipe_stage_skid_reg.sv
// Pipeline boundary register with flush, bubble, hold and an optional
// one-entry skid buffer that catches data arriving while the stage is stalled.
module pipe_stage_skid_reg
    import pipe_stage_skid_reg_pkg::*;
#(
    parameter int ADDR_W  = 32,
    parameter int DATA_W  = 32,
    parameter int STAGE   = PIPE_STAGE_IF,
    parameter bit SKID_EN = 1'b1
) (
    input logic                 clk,
    input logic                 rst,
    pipe_stage_skid_reg_if.slave bus
);

    pipe_action_e      act;
    logic              stalled;
    logic              skid_valid;
    logic [ADDR_W-1:0] skid_pc;
    logic [DATA_W-1:0] skid_inst;
    logic              id_valid_q;
    logic [ADDR_W-1:0] id_pc_q;
    logic [DATA_W-1:0] id_inst_q;
    logic              unused_stall;

    assign unused_stall = ^bus.stall;

    always_comb begin
        act     = decode_action(rst, bus.flush, bus.stall[STAGE], bus.stall[STAGE+1]);
        stalled = (act == ACT_BUBBLE) || (act == ACT_HOLD);
    end

    generate
        if (SKID_EN) begin : g_skid
            logic skid_load;
            logic skid_drain;
            logic skid_clear;

            // Capture while stalled into an empty entry, or refill while draining so
            // the newer beat queues behind the one leaving; a stalled beat that finds
            // the entry occupied is dropped and the older entry kept.
            always_comb begin
                skid_drain = (act == ACT_ADVANCE) && skid_valid;
                skid_load  = bus.if_valid && ((stalled && !skid_valid) || skid_drain);
                skid_clear = (act == ACT_FLUSH);
            end

            skid_entry #(
                .ADDR_W (ADDR_W),
                .DATA_W (DATA_W)
            ) u_skid (
                .clk      (clk),
                .rst      (rst),
                .load     (skid_load),
                .drain    (skid_drain),
                .clear    (skid_clear),
                .in_pc    (bus.if_pc),
                .in_inst  (bus.if_inst),
                .valid    (skid_valid),
                .out_pc   (skid_pc),
                .out_inst (skid_inst)
            );
        end else begin : g_no_skid
            assign skid_valid = 1'b0;
            assign skid_pc    = '0;
            assign skid_inst  = '0;
        end
    endgenerate

    always_ff @(posedge clk) begin
        case (act)
            ACT_RESET, ACT_FLUSH, ACT_BUBBLE: begin
                id_valid_q <= 1'b0;
                id_pc_q    <= '0;
                id_inst_q  <= '0;
            end
            ACT_HOLD: begin
                id_valid_q <= id_valid_q;
                id_pc_q    <= id_pc_q;
                id_inst_q  <= id_inst_q;
            end
            default: begin
                // A buffered entry always leaves before the beat presented this cycle.
                if (skid_valid) begin
                    id_valid_q <= 1'b1;
                    id_pc_q    <= skid_pc;
                    id_inst_q  <= skid_inst;
                end else begin
                    id_valid_q <= bus.if_valid;
                    id_pc_q    <= bus.if_valid ? bus.if_pc   : '0;
                    id_inst_q  <= bus.if_valid ? bus.if_inst : '0;
                end
            end
        endcase
    end

    assign bus.id_valid  = id_valid_q;
    assign bus.id_pc     = id_pc_q;
    assign bus.id_inst   = id_inst_q;
    assign bus.skid_full = skid_valid;

endmodule

// File: tb/tb_pipe_stage_skid_reg.sv
// Directed and randomized checks of the IF->ID boundary register against a
// queue-based model of the stage's priority rules.
module tb_pipe_stage_skid_reg;

    localparam int STAGE = 1;

    typedef struct {
        logic [31:0] pc;
        logic [31:0] inst;
    } entry_t;

    logic clk = 1'b0;
    logic rst = 1'b0;

    pipe_stage_skid_reg_if #(.ADDR_W(32), .DATA_W(32)) bus ();

    pipe_stage_skid_reg #(
        .ADDR_W  (32),
        .DATA_W  (32),
        .STAGE   (STAGE),
        .SKID_EN (1'b1)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    int     vectors     = 0;
    int     miscompares = 0;
    entry_t skid_q[$];
    logic        m_valid = 1'b0;
    logic [31:0] m_pc    = 32'h0;
    logic [31:0] m_inst  = 32'h0;

    function automatic logic [31:0] inst_of(input logic [31:0] pc);
        return (pc * 32'd3) ^ 32'h1357_9BDF;
    endfunction

    // Reference behaviour: stage register plus an ordered queue of at most one entry.
    function automatic void model_step(input logic rst_v, input logic [5:0] st, input logic fl,
                                       input logic v, input logic [31:0] pc, input logic [31:0] inst);
        entry_t e;
        e.pc   = pc;
        e.inst = inst;
        if (!rst_v || fl) begin
            m_valid = 1'b0; m_pc = 0; m_inst = 0;
            skid_q.delete();
        end else if (st[STAGE]) begin
            if (!st[STAGE+1]) begin
                m_valid = 1'b0; m_pc = 0; m_inst = 0;
            end
            if (v && skid_q.size() == 0) skid_q.push_back(e);
        end else if (skid_q.size() != 0) begin
            entry_t head = skid_q.pop_front();
            m_valid = 1'b1; m_pc = head.pc; m_inst = head.inst;
            if (v) skid_q.push_back(e);
        end else begin
            m_valid = v;
            m_pc    = v ? pc : 32'h0;
            m_inst  = v ? inst : 32'h0;
        end
    endfunction

    task automatic checkOutput(input string tag);
        vectors += 4;
        assert (bus.id_valid === m_valid) else begin
            miscompares++;
            $error("[TB] FAIL %s id_valid got %b want %b", tag, bus.id_valid, m_valid);
        end
        assert (bus.id_pc === m_pc) else begin
            miscompares++;
            $error("[TB] FAIL %s id_pc got %h want %h", tag, bus.id_pc, m_pc);
        end
        assert (bus.id_inst === m_inst) else begin
            miscompares++;
            $error("[TB] FAIL %s id_inst got %h want %h", tag, bus.id_inst, m_inst);
        end
        assert (bus.skid_full === (skid_q.size() != 0)) else begin
            miscompares++;
            $error("[TB] FAIL %s skid_full got %b want %b", tag, bus.skid_full, skid_q.size() != 0);
        end
    endtask

    task automatic checkLiteral(input string tag, input logic v, input logic [31:0] pc,
                                input logic full);
        vectors += 3;
        assert (bus.id_valid === v) else begin
            miscompares++;
            $error("[TB] FAIL %s id_valid got %b want %b", tag, bus.id_valid, v);
        end
        assert (bus.id_pc === pc) else begin
            miscompares++;
            $error("[TB] FAIL %s id_pc got %h want %h", tag, bus.id_pc, pc);
        end
        assert (bus.skid_full === full) else begin
            miscompares++;
            $error("[TB] FAIL %s skid_full got %b want %b", tag, bus.skid_full, full);
        end
    endtask

    task automatic applyStimulus(input string tag, input logic rst_v, input logic [5:0] st,
                                 input logic fl, input logic v, input logic [31:0] pc);
        logic [31:0] inst;
        inst         = v ? inst_of(pc) : $urandom;
        rst          = rst_v;
        bus.stall    = st;
        bus.flush    = fl;
        bus.if_valid = v;
        bus.if_pc    = pc;
        bus.if_inst  = inst;
        assert (!(rst_v && !fl && st[STAGE] && v && bus.skid_full)) else begin
            miscompares++;
            $error("[TB] FAIL %s protocol if_valid while skid full and stalled", tag);
        end
        @(posedge clk);
        model_step(rst_v, st, fl, v, pc, inst);
        #1;
        checkOutput(tag);
    endtask

    initial begin
        bus.stall    = 6'b0;
        bus.flush    = 1'b0;
        bus.if_valid = 1'b0;
        bus.if_pc    = 32'h0;
        bus.if_inst  = 32'h0;
        @(negedge clk);

        // Reset with random inputs, then idle after release.
        applyStimulus("rst0", 1'b0, 6'($urandom), 1'b0, 1'b1, $urandom);
        applyStimulus("rst1", 1'b0, 6'($urandom), 1'($urandom), 1'b1, $urandom);
        checkLiteral("rst_lit", 1'b0, 32'h0, 1'b0);
        applyStimulus("rel", 1'b1, 6'b0, 1'b0, 1'b0, 32'h0);
        checkLiteral("rel_lit", 1'b0, 32'h0, 1'b0);

        // Straight-through flow.
        applyStimulus("flow0", 1'b1, 6'b0, 1'b0, 1'b1, 32'hBFC0_0000);
        checkLiteral("flow0_lit", 1'b1, 32'hBFC0_0000, 1'b0);
        applyStimulus("flow1", 1'b1, 6'b0, 1'b0, 1'b1, 32'hBFC0_0004);
        checkLiteral("flow1_lit", 1'b1, 32'hBFC0_0004, 1'b0);

        // Bubble catches the beat in the skid, then it drains.
        applyStimulus("bub", 1'b1, 6'b000010, 1'b0, 1'b1, 32'h100);
        checkLiteral("bub_lit", 1'b0, 32'h0, 1'b1);
        applyStimulus("bub_drain", 1'b1, 6'b0, 1'b0, 1'b0, 32'h0);
        checkLiteral("bub_drain_lit", 1'b1, 32'h100, 1'b0);

        // Hold keeps the registered value.
        applyStimulus("hold_ld", 1'b1, 6'b0, 1'b0, 1'b1, 32'h200);
        for (int i = 0; i < 3; i++) begin
            applyStimulus("hold", 1'b1, 6'b000110, 1'b0, 1'b0, 32'h0);
            checkLiteral("hold_lit", 1'b1, 32'h200, 1'b0);
        end

        // Drain and refill in the same cycle preserves order.
        applyStimulus("sk_fill", 1'b1, 6'b000010, 1'b0, 1'b1, 32'h300);
        applyStimulus("sk_swap", 1'b1, 6'b0, 1'b0, 1'b1, 32'h304);
        checkLiteral("sk_swap_lit", 1'b1, 32'h300, 1'b1);
        applyStimulus("sk_last", 1'b1, 6'b0, 1'b0, 1'b0, 32'h0);
        checkLiteral("sk_last_lit", 1'b1, 32'h304, 1'b0);

        // Flush kills both the skid entry and the same-cycle beat.
        applyStimulus("fl_fill", 1'b1, 6'b000010, 1'b0, 1'b1, 32'h3A0);
        applyStimulus("flush", 1'b1, 6'b0, 1'b1, 1'b1, 32'h3A4);
        checkLiteral("flush_lit", 1'b0, 32'h0, 1'b0);
        applyStimulus("fl_after", 1'b1, 6'b0, 1'b0, 1'b0, 32'h0);
        checkLiteral("fl_after_lit", 1'b0, 32'h0, 1'b0);

        // Reset while the skid holds an entry leaves nothing behind.
        applyStimulus("rs_fill", 1'b1, 6'b000110, 1'b0, 1'b1, 32'h500);
        applyStimulus("rs_mid", 1'b0, 6'b0, 1'b0, 1'b1, 32'h504);
        checkLiteral("rs_mid_lit", 1'b0, 32'h0, 1'b0);
        applyStimulus("rs_after", 1'b1, 6'b0, 1'b0, 1'b0, 32'h0);
        checkLiteral("rs_after_lit", 1'b0, 32'h0, 1'b0);

        // Randomized traffic; unrelated stall bits are random too.
        for (int i = 0; i < 400; i++) begin
            logic [5:0]  st;
            logic        fl, v, rv;
            st        = 6'($urandom);
            st[STAGE] = ($urandom_range(0, 2) == 0);
            fl        = ($urandom_range(0, 15) == 0);
            rv        = ($urandom_range(0, 39) != 0);
            v         = 1'($urandom);
            if (rv && !fl && st[STAGE] && skid_q.size() != 0) v = 1'b0;
            applyStimulus("rand", rv, st, fl, v, {$urandom} & 32'hFFFF_FFFC);
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
